// File: rtl/pll_lock_supervisor_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : pll_sup_pkg
// Purpose  : Shared state encoding and widths for the PLL lock supervisor.
// Revision : 1.0
// ---------------------------------------------------------------------------
package pll_sup_pkg;

   localparam int CNT_W      = 16;
   localparam int SYNC_DEPTH = 2;

   typedef enum logic [2:0] {
      S_PLL_RST   = 3'd0,
      S_WAIT_LOCK = 3'd1,
      S_STABLE    = 3'd2,
      S_RUN       = 3'd3,
      S_FAIL      = 3'd4
   } state_t;

endpackage
`default_nettype wire

// File: rtl/pll_lock_supervisor_if.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : pll_lock_supervisor_if
// Purpose  : PLL control/status bundle between the supervisor and its PLL.
// Revision : 1.0
// ---------------------------------------------------------------------------
interface pll_lock_supervisor_if;
   import pll_sup_pkg::*;

   logic             pll_locked;
   logic             pll_outclk;
   logic             pll_rst;
   logic             sys_rst;
   logic             clk_ok;
   logic             fail;
   logic [1:0]       retry_cnt;
   logic [CNT_W-1:0] meas_count;

   modport master (
      input  pll_locked, pll_outclk,
      output pll_rst, sys_rst, clk_ok, fail, retry_cnt, meas_count
   );

   modport slave (
      output pll_locked, pll_outclk,
      input  pll_rst, sys_rst, clk_ok, fail, retry_cnt, meas_count
   );

endinterface
`default_nettype wire

// File: rtl/pll_lock_supervisor_clk_freq_meter.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : clk_freq_meter
// Purpose  : Counts synchronised outclk rising edges over a fixed refclk window.
// Revision : 1.0
// ---------------------------------------------------------------------------
module clk_freq_meter
   import pll_sup_pkg::*;
#(
   parameter int MEAS_WINDOW = 1000,
   parameter int EXP_COUNT   = 100,
   parameter int TOL         = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             outclk,
   output logic             win_done,
   output logic             pass,
   output logic [CNT_W-1:0] count
);

   localparam int               WIN_W    = (MEAS_WINDOW > 1) ? $clog2(MEAS_WINDOW) : 1;
   localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(MEAS_WINDOW - 1);
   localparam logic [CNT_W-1:0] EXP_C    = CNT_W'(EXP_COUNT);
   localparam logic [CNT_W-1:0] TOL_C    = CNT_W'(TOL);

   logic [SYNC_DEPTH-1:0] r_sync;
   logic                  r_prev;
   logic                  w_rise;
   logic [WIN_W-1:0]      r_win;
   logic [CNT_W-1:0]      r_edges;
   logic [CNT_W-1:0]      w_edges;
   logic [CNT_W-1:0]      w_diff;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync <= '0;
         r_prev <= 1'b0;
      end else begin
         r_sync <= {r_sync[SYNC_DEPTH-2:0], outclk};
         r_prev <= r_sync[SYNC_DEPTH-1];
      end
   end

   assign w_rise   = r_sync[SYNC_DEPTH-1] & ~r_prev;
   assign win_done = en && (r_win == WIN_LAST);
   // Running total including this cycle's edge, so the last window cycle is counted.
   assign w_edges  = (r_edges == {CNT_W{1'b1}}) ? r_edges : r_edges + CNT_W'(w_rise);
   assign w_diff   = (w_edges >= EXP_C) ? (w_edges - EXP_C) : (EXP_C - w_edges);
   assign pass     = (w_diff <= TOL_C);

   always_ff @(posedge clk) begin
      if (rst || !en || win_done) begin
         r_win   <= '0;
         r_edges <= '0;
      end else begin
         r_win   <= r_win + WIN_W'(1);
         r_edges <= w_edges;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (win_done) begin
         count <= w_edges;
      end
   end

endmodule
`default_nettype wire

// File: rtl/pll_lock_supervisor.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : pll_lock_supervisor
// Purpose  : Sequences PLL reset, qualifies lock and frequency, gates sys_rst.
// Revision : 1.0
// ---------------------------------------------------------------------------
module pll_lock_supervisor
   import pll_sup_pkg::*;
#(
   parameter int PLL_RST_CYCLES      = 16,
   parameter int LOCK_TIMEOUT_CYCLES = 65536,
   parameter int LOCK_STABLE_CYCLES  = 1024,
   parameter int MEAS_WINDOW         = 1000,
   parameter int EXP_COUNT           = 100,
   parameter int TOL                 = 2,
   parameter int MAX_RETRIES         = 3
) (
   input  logic                  refclk,
   input  logic                  rst,
   pll_lock_supervisor_if.master bus
);

   localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] STABLE_MAX   = CNT_W'(LOCK_STABLE_CYCLES);
   localparam logic [1:0]       RETRY_MAX    = 2'(MAX_RETRIES);

   logic [SYNC_DEPTH-1:0] r_lock_sync;
   logic                  w_locked_s;
   state_t                r_state, w_next;
   logic [CNT_W-1:0]      r_cnt, w_cnt_next;
   logic [1:0]            r_retry, w_retry_next;
   logic                  w_retry_req;
   logic                  w_meter_en, w_win_done, w_pass;
   logic                  r_pll_rst, r_sys_rst, r_clk_ok, r_fail;

   always_ff @(posedge refclk) begin
      if (rst) r_lock_sync <= '0;
      else     r_lock_sync <= {r_lock_sync[SYNC_DEPTH-2:0], bus.pll_locked};
   end
   assign w_locked_s = r_lock_sync[SYNC_DEPTH-1];

   assign w_meter_en = (r_state == S_STABLE) || (r_state == S_RUN);

   clk_freq_meter #(
      .MEAS_WINDOW (MEAS_WINDOW),
      .EXP_COUNT   (EXP_COUNT),
      .TOL         (TOL)
   ) u_meter (
      .clk      (refclk),
      .rst      (rst),
      .en       (w_meter_en),
      .outclk   (bus.pll_outclk),
      .win_done (w_win_done),
      .pass     (w_pass),
      .count    (bus.meas_count)
   );

   always_comb begin
      w_next       = r_state;
      w_cnt_next   = r_cnt;
      w_retry_next = r_retry;
      w_retry_req  = 1'b0;
      case (r_state)
         S_PLL_RST: begin
            if (r_cnt == RST_LAST) begin
               w_next     = S_WAIT_LOCK;
               w_cnt_next = '0;
            end else begin
               w_cnt_next = r_cnt + CNT_W'(1);
            end
         end
         S_WAIT_LOCK: begin
            if (w_locked_s) begin
               w_next     = S_STABLE;
               w_cnt_next = '0;
            end else if (r_cnt == TIMEOUT_LAST) begin
               w_retry_req = 1'b1;
            end else begin
               w_cnt_next = r_cnt + CNT_W'(1);
            end
         end
         S_STABLE: begin
            // Lock loss wins over a coincident window result.
            if (!w_locked_s) begin
               w_next     = S_WAIT_LOCK;
               w_cnt_next = '0;
            end else if (w_win_done && !w_pass) begin
               w_retry_req = 1'b1;
            end else if (w_win_done && (r_cnt >= STABLE_MAX)) begin
               w_next       = S_RUN;
               w_cnt_next   = '0;
               w_retry_next = '0;
            end else if (r_cnt < STABLE_MAX) begin
               w_cnt_next = r_cnt + CNT_W'(1);
            end
         end
         S_RUN: begin
            if (!w_locked_s || (w_win_done && !w_pass)) w_retry_req = 1'b1;
         end
         S_FAIL: begin
            w_next = S_FAIL;
         end
         default: begin
            w_next     = S_PLL_RST;
            w_cnt_next = '0;
         end
      endcase

      if (w_retry_req) begin
         w_cnt_next = '0;
         if (r_retry == RETRY_MAX) begin
            w_next = S_FAIL;
         end else begin
            w_next       = S_PLL_RST;
            w_retry_next = r_retry + 2'd1;
         end
      end
   end

   always_ff @(posedge refclk) begin
      if (rst) begin
         r_state   <= S_PLL_RST;
         r_cnt     <= '0;
         r_retry   <= '0;
         r_pll_rst <= 1'b1;
         r_sys_rst <= 1'b1;
         r_clk_ok  <= 1'b0;
         r_fail    <= 1'b0;
      end else begin
         r_state   <= w_next;
         r_cnt     <= w_cnt_next;
         r_retry   <= w_retry_next;
         r_pll_rst <= (w_next == S_PLL_RST);
         r_sys_rst <= (w_next != S_RUN);
         r_clk_ok  <= (w_next == S_RUN);
         r_fail    <= (w_next == S_FAIL);
      end
   end

   assign bus.pll_rst   = r_pll_rst;
   assign bus.sys_rst   = r_sys_rst;
   assign bus.clk_ok    = r_clk_ok;
   assign bus.fail      = r_fail;
   assign bus.retry_cnt = r_retry;

endmodule
`default_nettype wire

// File: tb/tb_pll_lock_supervisor.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : tb_pll_lock_supervisor
// Purpose  : Self-checking bench against a timeline model of the supervisor.
// Revision : 1.0
// ---------------------------------------------------------------------------
module tb_pll_lock_supervisor;
   import pll_sup_pkg::*;

   localparam int P_RST   = 16;
   localparam int P_TO    = 256;
   localparam int P_STB   = 64;
   localparam int P_WIN   = 100;
   localparam int P_EXP   = 10;
   localparam int P_TOL   = 1;
   localparam int P_RETRY = 3;
   localparam int SYNC_LAT = 2;

   logic refclk = 1'b0;
   logic rst    = 1'b1;
   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;
   int   half_ns = 100;

   pll_lock_supervisor_if bus ();

   pll_lock_supervisor #(
      .PLL_RST_CYCLES      (P_RST),
      .LOCK_TIMEOUT_CYCLES (P_TO),
      .LOCK_STABLE_CYCLES  (P_STB),
      .MEAS_WINDOW         (P_WIN),
      .EXP_COUNT           (P_EXP),
      .TOL                 (P_TOL),
      .MAX_RETRIES         (P_RETRY)
   ) dut (
      .refclk (refclk),
      .rst    (rst),
      .bus    (bus)
   );

   always #10 refclk = ~refclk;

   // Offset of 3 ns keeps outclk transitions off refclk rising edges.
   initial begin
      bus.pll_outclk = 1'b0;
      #3;
      forever begin
         #(half_ns) bus.pll_outclk = ~bus.pll_outclk;
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached at cyc=%0d", cyc);
      $fatal(1);
   end

   task automatic tick();
      @(posedge refclk);
      #1;
      cyc++;
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      bus.pll_locked = 1'b0;
      repeat (2) tick();
      rst = 1'b0;
      cyc = 0;
   endtask

   function automatic logic [5:0] obs();
      return {bus.pll_rst, bus.sys_rst, bus.clk_ok, bus.fail, bus.retry_cnt};
   endfunction

   // First S_STABLE cycle: lock seen after the synchroniser, and not before waiting starts.
   function automatic int stable_entry(input int lock_at, input int wait_start);
      int seen;
      seen = lock_at + SYNC_LAT;
      return ((seen > wait_start) ? seen : wait_start) + 1;
   endfunction

   function automatic logic [5:0] ref_bringup(input int c, input int run_at);
      logic prst, up;
      prst = (c < P_RST);
      up   = (c >= run_at);
      return {prst, ~up, up, 1'b0, 2'd0};
   endfunction

   task automatic test_reset();
      rst = 1'b1;
      bus.pll_locked = 1'b0;
      repeat (3) tick();
      checks++;
      if (obs() !== 6'b110000) begin
         errors++;
         $display("FAIL reset_outputs got=%b exp=%b", obs(), 6'b110000);
      end
      checks++;
      if (bus.meas_count !== 16'd0) begin
         errors++;
         $display("FAIL reset_meas got=%0d exp=0", bus.meas_count);
      end
   endtask

   task automatic test_nominal(input int lock_at, input int period);
      int run_at;
      logic [5:0] exp;
      logic [15:0] lo, hi;
      half_ns = period * 10;
      apply_reset();
      run_at = stable_entry(lock_at, P_RST) + P_WIN;
      for (int c = 0; c < run_at + 2 * P_WIN; c++) begin
         exp = ref_bringup(cyc, run_at);
         checks++;
         if (obs() !== exp) begin
            errors++;
            $display("FAIL nominal lock=%0d per=%0d cyc=%0d got=%b exp=%b", lock_at, period, cyc, obs(), exp);
         end
         if (cyc == lock_at) bus.pll_locked = 1'b1;
         tick();
      end
      lo = 16'(P_WIN / period);
      hi = 16'((P_WIN + period - 1) / period);
      checks++;
      if (bus.meas_count !== lo && bus.meas_count !== hi) begin
         errors++;
         $display("FAIL nominal_meas got=%0d exp=%0d..%0d", bus.meas_count, lo, hi);
      end
   endtask

   task automatic test_no_lock();
      int per, fail_at, n;
      logic [5:0] exp;
      logic prst, fl;
      half_ns = 100;
      apply_reset();
      per     = P_RST + P_TO;
      fail_at = (P_RETRY + 1) * per;
      for (int c = 0; c < fail_at + 200; c++) begin
         n    = (cyc / per > P_RETRY) ? P_RETRY : cyc / per;
         prst = (cyc < fail_at) && ((cyc % per) < P_RST);
         fl   = (cyc >= fail_at);
         exp  = {prst, 1'b1, 1'b0, fl, 2'(n)};
         checks++;
         if (obs() !== exp) begin
            errors++;
            $display("FAIL no_lock cyc=%0d got=%b exp=%b", cyc, obs(), exp);
         end
         tick();
      end
   endtask

   task automatic test_lock_loss_run();
      int lock_at, run_at, drop_at, run2;
      logic [5:0] exp;
      half_ns = 100;
      lock_at = int'($urandom_range(60, 0));
      apply_reset();
      run_at  = stable_entry(lock_at, P_RST) + P_WIN;
      drop_at = run_at + int'($urandom_range(40, 5));
      run2    = stable_entry(drop_at + 1, drop_at + 3 + P_RST) + P_WIN;
      for (int c = 0; c < run2 + 20; c++) begin
         if (cyc < drop_at + 3)              exp = ref_bringup(cyc, run_at);
         else if (cyc < drop_at + 3 + P_RST) exp = 6'b110001;
         else if (cyc < run2)                exp = 6'b010001;
         else                                exp = 6'b001000;
         checks++;
         if (obs() !== exp) begin
            errors++;
            $display("FAIL lock_loss_run drop=%0d cyc=%0d got=%b exp=%b", drop_at, cyc, obs(), exp);
         end
         bus.pll_locked = (cyc >= lock_at) && (cyc != drop_at);
         tick();
      end
   endtask

   task automatic test_freq_error();
      int lock_at, retry_at, per, fail_at, n;
      logic [5:0] exp;
      logic prst, fl;
      half_ns = 80;
      lock_at = int'($urandom_range(60, 0));
      apply_reset();
      retry_at = stable_entry(lock_at, P_RST) + P_WIN;
      // Each retry: reset pulse, one wait cycle (lock already seen), one window.
      per      = P_RST + 1 + P_WIN;
      fail_at  = retry_at + P_RETRY * per;
      for (int c = 0; c < fail_at + 60; c++) begin
         n    = (cyc < retry_at) ? 0 : (cyc - retry_at) / per + 1;
         if (n > P_RETRY) n = P_RETRY;
         prst = (cyc < P_RST) ||
                ((cyc >= retry_at) && (cyc < fail_at) && (((cyc - retry_at) % per) < P_RST));
         fl   = (cyc >= fail_at);
         exp  = {prst, 1'b1, 1'b0, fl, 2'(n)};
         checks++;
         if (obs() !== exp) begin
            errors++;
            $display("FAIL freq_error cyc=%0d got=%b exp=%b", cyc, obs(), exp);
         end
         bus.pll_locked = (cyc >= lock_at);
         tick();
      end
      checks++;
      if (bus.meas_count !== 16'd12 && bus.meas_count !== 16'd13) begin
         errors++;
         $display("FAIL freq_error_meas got=%0d exp=12..13", bus.meas_count);
      end
      rst = 1'b1;
      tick();
      checks++;
      if (obs() !== 6'b110000 || bus.meas_count !== 16'd0) begin
         errors++;
         $display("FAIL reset_from_fail got=%b meas=%0d exp=110000 meas=0", obs(), bus.meas_count);
      end
      rst = 1'b0;
   endtask

   task automatic test_stable_drop(input int offset);
      int lock_at, drop_at, run_at;
      logic [5:0] exp;
      half_ns = 100;
      lock_at = int'($urandom_range(60, 0));
      apply_reset();
      drop_at = stable_entry(lock_at, P_RST) + offset;
      run_at  = stable_entry(drop_at + 1, drop_at + SYNC_LAT + 1) + P_WIN;
      for (int c = 0; c < run_at + 20; c++) begin
         exp = ref_bringup(cyc, run_at);
         checks++;
         if (obs() !== exp) begin
            errors++;
            $display("FAIL stable_drop off=%0d cyc=%0d got=%b exp=%b", offset, cyc, obs(), exp);
         end
         bus.pll_locked = (cyc >= lock_at) && (cyc != drop_at);
         tick();
      end
   endtask

   task automatic test_rst_in_run();
      int lock_at, run_at;
      logic [5:0] exp;
      half_ns = 100;
      lock_at = int'($urandom_range(60, 0));
      apply_reset();
      run_at = stable_entry(lock_at, P_RST) + P_WIN;
      while (cyc < run_at + 10) begin
         bus.pll_locked = (cyc >= lock_at);
         tick();
      end
      checks++;
      if (obs() !== 6'b001000 || bus.meas_count !== 16'd10) begin
         errors++;
         $display("FAIL rst_in_run_pre got=%b meas=%0d exp=001000 meas=10", obs(), bus.meas_count);
      end
      rst = 1'b1;
      tick();
      checks++;
      if (obs() !== 6'b110000 || bus.meas_count !== 16'd0) begin
         errors++;
         $display("FAIL rst_in_run got=%b meas=%0d exp=110000 meas=0", obs(), bus.meas_count);
      end
      rst = 1'b0;
      cyc = 0;
      run_at = stable_entry(0, P_RST) + P_WIN;
      for (int c = 0; c < run_at + 20; c++) begin
         exp = ref_bringup(cyc, run_at);
         checks++;
         if (obs() !== exp) begin
            errors++;
            $display("FAIL rst_in_run_restart cyc=%0d got=%b exp=%b", cyc, obs(), exp);
         end
         tick();
      end
   endtask

   task automatic test_random();
      int lock_at, period;
      for (int i = 0; i < 4; i++) begin
         lock_at = int'($urandom_range(150, 0));
         period  = ($urandom_range(1, 0) == 1) ? 11 : 10;
         test_nominal(lock_at, period);
      end
   endtask

   initial begin
      bus.pll_locked = 1'b0;
      test_reset();
      test_nominal(40, 10);
      test_no_lock();
      test_lock_loss_run();
      test_freq_error();
      test_stable_drop(30);
      test_stable_drop(int'($urandom_range(90, 5)));
      test_rst_in_run();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
